row_clear_sequencer: RTL and testbench

//  Sequences row clearing after a piece locks. Sits between the piece/movement logic and the

---
 rtl/tetris_pkg.sv | 16 +
 rtl/row_clear_sequencer.sv | 160 ++++++++++++++++
 tb/tb_row_clear_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, row types, sequencer state encoding and line-clear score table.
package tetris_pkg;

  localparam int unsigned BOARD_COLS = 10;
  localparam int unsigned BOARD_ROWS = 20;
  localparam int unsigned ROW_W      = 7;

  typedef logic [BOARD_COLS-1:0] row_t;
  typedef logic [ROW_W-1:0]      row_idx_t;

  typedef enum logic [1:0] {IDLE, SCAN, FILL, REPORT} rcs_state_t;

  localparam logic [19:0] SCORE_TABLE [5] = '{20'd0, 20'd40, 20'd100, 20'd300, 20'd1200};
  localparam logic [19:0] SCORE_MAX       = 20'hFFFFF;

endpackage

// File: rtl/row_clear_sequencer.sv
// Removes full rows after a piece locks: scans bottom-up, compacts survivors down, zero-fills the top.
// Optional score accumulator is enabled with `define ROW_CLEAR_SCORE_EN.
module row_clear_sequencer
  import tetris_pkg::*;
(
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic                  lock_valid,
  output logic                  lock_ready,
  input  logic [ROW_W-1:0]      lock_row_lo,
  input  logic [ROW_W-1:0]      lock_row_hi,
  output logic [ROW_W-1:0]      rd_row,
  input  logic [BOARD_COLS-1:0] rd_data,
  output logic                  wr_en,
  output logic [ROW_W-1:0]      wr_row,
  output logic [BOARD_COLS-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  Clear_row,
  output logic [3:0]            Num_rows_to_clear,
  output logic [ROW_W-1:0]      Row_to_clear
`ifdef ROW_CLEAR_SCORE_EN
  ,
  output logic [19:0]           score
`endif
);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_SCAN   = 2'(SCAN);
  localparam logic [1:0] S_FILL   = 2'(FILL);
  localparam logic [1:0] S_REPORT = 2'(REPORT);
  localparam row_idx_t   LAST_ROW = ROW_W'(BOARD_ROWS - 1);

  logic [1:0] r_state, w_state_nxt;
  row_idx_t   r_r, w_r_nxt;
  row_idx_t   r_w, w_w_nxt;
  row_idx_t   r_lo, w_lo_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  row_idx_t   r_first, w_first_nxt;
  row_idx_t   w_hi_clamp;
  logic       w_full;
  logic       w_wr_en;
  row_t       w_wr_data;

  logic       r_lock_ready, r_busy, r_done, r_clear_row;
  logic [3:0] r_num;
  row_idx_t   r_row_to_clear;

  // Next-state, pointer and board-write decode
  always_comb begin
    w_state_nxt = r_state;
    w_r_nxt     = r_r;
    w_w_nxt     = r_w;
    w_lo_nxt    = r_lo;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = r_first;
    w_wr_en     = 1'b0;
    w_wr_data   = rd_data;
    w_full      = &rd_data;
    w_hi_clamp  = (lock_row_hi > LAST_ROW) ? LAST_ROW : lock_row_hi;
    case (r_state)
      S_IDLE: begin
        if (lock_valid && r_lock_ready) begin
          w_state_nxt = S_SCAN;
          w_r_nxt     = w_hi_clamp;
          w_w_nxt     = w_hi_clamp;
          w_lo_nxt    = (lock_row_lo < w_hi_clamp) ? lock_row_lo : w_hi_clamp;
          w_cnt_nxt   = 3'd0;
          w_first_nxt = '0;
        end
      end
      S_SCAN: begin
        w_r_nxt = r_r - ROW_W'(1);
        if (w_full) begin
          w_cnt_nxt = (r_cnt == 3'd4) ? 3'd4 : r_cnt + 3'd1;
          if (r_cnt == 3'd0) w_first_nxt = r_r;
        end else begin
          // w trails r, so a survivor is only rewritten once a full row has been skipped
          w_wr_en = (r_w != r_r);
          w_w_nxt = r_w - ROW_W'(1);
        end
        if (r_r == r_lo && w_cnt_nxt == 3'd0) w_state_nxt = S_REPORT;
        else if (r_r == '0) w_state_nxt = (w_cnt_nxt != 3'd0) ? S_FILL : S_REPORT;
      end
      S_FILL: begin
        w_wr_en   = 1'b1;
        w_wr_data = '0;
        w_w_nxt   = r_w - ROW_W'(1);
        if (r_w == '0) w_state_nxt = S_REPORT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rd_row  = r_r;
  assign wr_en   = w_wr_en;
  assign wr_row  = r_w;
  assign wr_data = w_wr_data;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_r     <= '0;
      r_w     <= '0;
      r_lo    <= '0;
      r_cnt   <= 3'd0;
      r_first <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_r     <= w_r_nxt;
      r_w     <= w_w_nxt;
      r_lo    <= w_lo_nxt;
      r_cnt   <= w_cnt_nxt;
      r_first <= w_first_nxt;
    end
  end

  // Status/report registers, loaded on entry to the state they describe
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_lock_ready   <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_clear_row    <= 1'b0;
      r_num          <= 4'd0;
      r_row_to_clear <= '0;
    end else begin
      r_lock_ready <= (w_state_nxt == S_IDLE);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_REPORT);
      r_clear_row  <= (w_state_nxt == S_REPORT) && (w_cnt_nxt != 3'd0);
      if (w_state_nxt == S_REPORT) begin
        r_num          <= 4'(w_cnt_nxt);
        r_row_to_clear <= w_first_nxt;
      end
    end
  end

  assign lock_ready        = r_lock_ready;
  assign busy              = r_busy;
  assign done              = r_done;
  assign Clear_row         = r_clear_row;
  assign Num_rows_to_clear = r_num;
  assign Row_to_clear      = r_row_to_clear;

`ifdef ROW_CLEAR_SCORE_EN
  logic [19:0] r_score;
  logic [20:0] w_score_sum;

  assign w_score_sum = {1'b0, r_score} + {1'b0, SCORE_TABLE[w_cnt_nxt]};

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) r_score <= 20'd0;
    else if (w_state_nxt == S_REPORT) r_score <= w_score_sum[20] ? SCORE_MAX : w_score_sum[19:0];
  end

  assign score = r_score;
`endif

endmodule

// File: tb/tb_row_clear_sequencer.sv
// Directed bench for row_clear_sequencer: board model, reference compaction model and result scoreboard.
module tb_row_clear_sequencer;
  import tetris_pkg::*;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       lock_valid;
  logic       lock_ready;
  logic [6:0] lock_row_lo, lock_row_hi;
  logic [6:0] rd_row;
  row_t       rd_data;
  logic       wr_en;
  logic [6:0] wr_row;
  row_t       wr_data;
  logic       busy, done, Clear_row;
  logic [3:0] Num_rows_to_clear;
  logic [6:0] Row_to_clear;
`ifdef ROW_CLEAR_SCORE_EN
  logic [19:0] score;
`endif

  row_clear_sequencer dut (
    .frame_clk(frame_clk), .Reset(Reset),
    .lock_valid(lock_valid), .lock_ready(lock_ready),
    .lock_row_lo(lock_row_lo), .lock_row_hi(lock_row_hi),
    .rd_row(rd_row), .rd_data(rd_data),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .busy(busy), .done(done), .Clear_row(Clear_row),
    .Num_rows_to_clear(Num_rows_to_clear), .Row_to_clear(Row_to_clear)
`ifdef ROW_CLEAR_SCORE_EN
    , .score(score)
`endif
  );

  always #5 frame_clk = ~frame_clk;

  row_t board      [20];
  row_t init_board [20];
  row_t exp_board  [20];
  logic do_load;
  int   wr_cnt = 0;

  // Board row store: bulk preload from the bench, otherwise DUT writes
  always @(posedge frame_clk) begin
    if (do_load) board <= init_board;
    else if (wr_en) begin
      if (wr_row < 7'd20) board[5'(wr_row)] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  assign rd_data = (rd_row < 7'd20) ? board[5'(rd_row)] : '0;

  typedef struct {
    int          num;
    int          rtc;
    int          lat;
    int          writes;
    logic [19:0] score;
  } exp_t;

  exp_t        sb_q[$];
  logic [19:0] model_score = 20'd0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Random non-full rows everywhere (bit 0 forced low)
  task automatic fill_random();
    for (int i = 0; i < 20; i++) init_board[i] = row_t'($urandom) & 10'h3FE;
  endtask

  task automatic load_board();
    @(negedge frame_clk) do_load = 1'b1;
    @(negedge frame_clk) do_load = 1'b0;
  endtask

  // Reference: remove full rows, shift survivors down, zero the top
  task automatic push_model(input int lo_in, input int hi_in);
    exp_t e;
    int   r0, lo, nfull;
    bit   any;
    logic [19:0] table_v [5] = '{20'd0, 20'd40, 20'd100, 20'd300, 20'd1200};
    r0 = (hi_in > 19) ? 19 : hi_in;
    lo = (lo_in < r0) ? lo_in : r0;
    exp_board = init_board;
    any = 0;
    for (int r = lo; r <= r0; r++) if (init_board[r] == 10'h3FF) any = 1;
    e.writes = 0; e.rtc = 0; nfull = 0;
    if (!any) begin
      e.lat = r0 - lo + 2;
    end else begin
      for (int r = r0; r >= 0; r--) begin
        if (init_board[r] == 10'h3FF) begin
          if (nfull == 0) e.rtc = r;
          nfull++;
        end else begin
          if (nfull > 0) e.writes++;
          exp_board[r + nfull] = init_board[r];
        end
      end
      for (int r = 0; r < nfull; r++) exp_board[r] = '0;
      e.writes += nfull;
      e.lat = r0 + 2 + nfull;
    end
    e.num = (nfull > 4) ? 4 : nfull;
    if ({1'b0, model_score} + {1'b0, table_v[e.num]} > 21'hFFFFF) model_score = 20'hFFFFF;
    else model_score = model_score + table_v[e.num];
    e.score = model_score;
    sb_q.push_back(e);
  endtask

  task automatic run_lock(input string nm, input int lo, input int hi);
    exp_t e;
    bit   got;
    int   lat, w0;
    push_model(lo, hi);
    @(negedge frame_clk);
    lock_row_lo = 7'(lo);
    lock_row_hi = 7'(hi);
    lock_valid  = 1'b1;
    w0  = wr_cnt;
    got = 0;
    lat = 0;
    for (int k = 1; k <= 200 && !got; k++) begin
      @(posedge frame_clk); #1;
      lock_valid = 1'b0;
      if (done) begin got = 1; lat = k; end
    end
    check({nm, " done_seen"}, 32'(got), 32'd1);
    e = sb_q.pop_front();
    if (got) begin
      check({nm, " latency"},   32'(lat), 32'(e.lat));
      check({nm, " num"},       32'(Num_rows_to_clear), 32'(e.num));
      check({nm, " row_clear"}, 32'(Row_to_clear), 32'(e.rtc));
      check({nm, " clear_row"}, 32'(Clear_row), 32'(e.num != 0));
      check({nm, " writes"},    32'(wr_cnt - w0), 32'(e.writes));
`ifdef ROW_CLEAR_SCORE_EN
      check({nm, " score"},     32'(score), 32'(e.score));
`endif
      for (int i = 0; i < 20; i++)
        check($sformatf("%s board[%0d]", nm, i), 32'(board[i]), 32'(exp_board[i]));
      @(posedge frame_clk); #1;
      check({nm, " done_pulse"}, 32'(done), 32'd0);
      check({nm, " ready_back"}, 32'(lock_ready), 32'd1);
    end
  endtask

  initial begin
    Reset       = 1'b1;
    lock_valid  = 1'b0;
    lock_row_lo = '0;
    lock_row_hi = '0;
    do_load     = 1'b0;
    for (int i = 0; i < 20; i++) init_board[i] = '0;
    #12;
    check("rst wr_en", 32'(wr_en), 32'd0);
    check("rst done",  32'(done), 32'd0);
    check("rst busy",  32'(busy), 32'd0);
    check("rst num",   32'(Num_rows_to_clear), 32'd0);
    @(negedge frame_clk) Reset = 1'b0;
    @(posedge frame_clk); #1;
    check("rst ready", 32'(lock_ready), 32'd1);

    // 1: no full row, fast path
    fill_random();
    load_board();
    run_lock("t1", 17, 18);

    // 2: single clear at the bottom
    fill_random();
    init_board[19] = 10'h3FF;
    init_board[18] = 10'h0F0;
    load_board();
    run_lock("t2", 18, 19);

    // 5: busy with request held, then reset mid-scan
    fill_random();
    init_board[19] = 10'h3FF;
    load_board();
    @(negedge frame_clk);
    lock_row_lo = 7'd18;
    lock_row_hi = 7'd19;
    lock_valid  = 1'b1;
    @(posedge frame_clk); #1;
    @(posedge frame_clk); #1;
    check("t5 ready_busy", 32'(lock_ready), 32'd0);
    check("t5 busy",       32'(busy), 32'd1);
    @(posedge frame_clk); #1;
    check("t5 wr_before", 32'(wr_en), 32'd1);
    Reset = 1'b1;
    #1;
    check("t5 wr_en",  32'(wr_en), 32'd0);
    check("t5 done",   32'(done), 32'd0);
    check("t5 clr",    32'(Clear_row), 32'd0);
    check("t5 num",    32'(Num_rows_to_clear), 32'd0);
    check("t5 rtc",    32'(Row_to_clear), 32'd0);
    check("t5 busy0",  32'(busy), 32'd0);
`ifdef ROW_CLEAR_SCORE_EN
    check("t5 score",  32'(score), 32'd0);
`endif
    model_score = 20'd0;
    lock_valid  = 1'b0;
    @(negedge frame_clk) Reset = 1'b0;
    begin
      int w0;
      w0 = wr_cnt;
      @(posedge frame_clk); #1;
      check("t5 ready1", 32'(lock_ready), 32'd1);
      repeat (5) @(posedge frame_clk);
      #1;
      check("t5 no_wr", 32'(wr_cnt - w0), 32'd0);
      check("t5 idle",  32'(busy), 32'd0);
    end

    // 3: tetris
    fill_random();
    for (int i = 16; i < 20; i++) init_board[i] = 10'h3FF;
    init_board[15] = 10'h001;
    load_board();
    run_lock("t3", 16, 19);

    // 4: split clear
    fill_random();
    init_board[19] = 10'h3FF;
    init_board[17] = 10'h3FF;
    init_board[18] = 10'h00F;
    load_board();
    run_lock("t4", 17, 19);

    // 6: out-of-range lock rows clamp to the bottom row
    fill_random();
    init_board[19] = 10'h3FF;
    load_board();
    run_lock("t6", 30, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
